axil_flash_bridge: RTL and testbench

- AXI4-Lite slave that turns register-mapped accesses into single-word QSPI flash operations: read, program, sector erase, block erase.
- Sits between the SoC AXI-Lite interconnect and the low-level QSPI engine; drives that engine over a start/valid/busy backend port.
- Next-generation bridge with a parametrised address map.
- AW and W are accepted independently; every response is held until the master accepts it.
- Read/write arbitration is fair.
- Adds a status/control CSR, a completion timeout, and SLVERR reporting.

---
 rtl/axil_flash_pkg.sv | 37 +++
 rtl/axil_flash_req_decode.sv | 49 ++++
 rtl/axil_flash_bridge.sv | 203 ++++++++++++++++++++
 tb/tb_axil_flash_bridge.sv | 376 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_flash_pkg.sv
// Shared types and constants for the AXI-Lite to QSPI flash bridge.
package axil_flash_pkg;

  // op field values taken from ADDR[OP_LSB+2:OP_LSB]
  localparam logic [2:0] OP_CSR  = 3'b000;
  localparam logic [2:0] OP_DATA = 3'b001;
  localparam logic [2:0] OP_SECT = 3'b010;
  localparam logic [2:0] OP_BLK  = 3'b100;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // read data returned when the backend never completes
  localparam logic [31:0] TIMEOUT_FILL = 32'hDEAD_BEEF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR_WAIT,
    ST_RD_WAIT,
    ST_B_RESP,
    ST_R_RESP
  } state_e;

  typedef enum logic [1:0] {
    K_CSR,
    K_DATA,
    K_SECT,
    K_BLK
  } op_kind_e;

  // classification of one captured request
  typedef struct packed {
    op_kind_e kind;
    logic     illegal;
  } req_cls_t;

endpackage

// File: rtl/axil_flash_req_decode.sv
// Combinational request classifier shared by the write and read paths.
module axil_flash_req_decode
  import axil_flash_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int OP_LSB = 24
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [3:0]        strb,
  input  logic              is_write,
  output req_cls_t          cls
);

  logic [2:0] op;
  assign op = addr[OP_LSB+2:OP_LSB];

  // address bits above the op field carry no meaning for the bridge
  if (ADDR_W > OP_LSB + 3) begin : g_hi
    logic unused_hi;
    assign unused_hi = ^addr[ADDR_W-1:OP_LSB+3];
  end

  // map op field to kind; flag anything the backend must not see
  always_comb begin
    cls.kind    = K_CSR;
    cls.illegal = 1'b0;
    case (op)
      OP_CSR: begin
        cls.kind    = K_CSR;
        cls.illegal = |addr[OP_LSB-1:0];
      end
      OP_DATA: begin
        cls.kind    = K_DATA;
        cls.illegal = is_write && (strb != 4'hF);
      end
      OP_SECT: begin
        cls.kind    = K_SECT;
        cls.illegal = !is_write;
      end
      OP_BLK: begin
        cls.kind    = K_BLK;
        cls.illegal = !is_write;
      end
      default: cls.illegal = 1'b1;
    endcase
    if (addr[1:0] != 2'b00) cls.illegal = 1'b1;
  end

endmodule

// File: rtl/axil_flash_bridge.sv
// AXI4-Lite slave turning register accesses into single-word QSPI flash ops.
module axil_flash_bridge
  import axil_flash_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int FLASH_AW    = 24,
  parameter int OP_LSB      = 24,
  parameter int TIMEOUT_CYC = 1048576
) (
  input  logic                ACLK,
  input  logic                ARESET,
  input  logic [ADDR_W-1:0]   AWADDR,
  input  logic [2:0]          AWPROT,
  input  logic                AWVALID,
  output logic                AWREADY,
  input  logic [31:0]         WDATA,
  input  logic [3:0]          WSTRB,
  input  logic                WVALID,
  output logic                WREADY,
  output logic                BVALID,
  output logic [1:0]          BRESP,
  input  logic                BREADY,
  input  logic [ADDR_W-1:0]   ARADDR,
  input  logic [2:0]          ARPROT,
  input  logic                ARVALID,
  output logic                ARREADY,
  output logic                RVALID,
  output logic [31:0]         RDATA,
  output logic [1:0]          RRESP,
  input  logic                RREADY,
  output logic                ll_start,
  output logic                ll_dir,
  output logic                ll_erase,
  output logic                ll_erase_blk,
  output logic                ll_spd,
  output logic [FLASH_AW-1:0] ll_address,
  output logic [31:0]         ll_word,
  input  logic [31:0]         ll_word_in,
  input  logic                ll_valid,
  input  logic                ll_busy
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  state_e            state, state_nxt;
  logic              rdy_en, pri_rd, tmo_sticky;
  logic              aw_full, w_full, ar_full;
  logic [ADDR_W-1:0] aw_addr, ar_addr;
  logic [31:0]       w_data;
  logic [3:0]        w_strb;
  logic [CNT_W-1:0]  cnt;
  logic              wr_pend, rd_pend, sel_wr, sel_rd, tmo_hit;
  req_cls_t          wr_cls, rd_cls;

  logic unused_prot;
  assign unused_prot = ^{AWPROT, ARPROT};

  assign wr_pend = aw_full && w_full;
  assign rd_pend = ar_full;
  assign tmo_hit = (cnt == CNT_W'(TIMEOUT_CYC - 1));

  axil_flash_req_decode #(.ADDR_W(ADDR_W), .OP_LSB(OP_LSB)) u_wr_dec (
    .addr(aw_addr), .strb(w_strb), .is_write(1'b1), .cls(wr_cls)
  );

  axil_flash_req_decode #(.ADDR_W(ADDR_W), .OP_LSB(OP_LSB)) u_rd_dec (
    .addr(ar_addr), .strb(4'hF), .is_write(1'b0), .cls(rd_cls)
  );

  // state register
  always_ff @(posedge ACLK) begin
    if (ARESET) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // next state, arbitration pick and handshake outputs
  always_comb begin
    state_nxt = state;
    sel_wr    = 1'b0;
    sel_rd    = 1'b0;
    AWREADY   = rdy_en && !aw_full;
    WREADY    = rdy_en && !w_full;
    ARREADY   = rdy_en && !ar_full;
    ll_start  = (state == ST_WR_WAIT) || (state == ST_RD_WAIT);
    BVALID    = (state == ST_B_RESP);
    RVALID    = (state == ST_R_RESP);
    case (state)
      ST_IDLE: if (!ll_busy) begin
        if (wr_pend && (!rd_pend || !pri_rd)) sel_wr = 1'b1;
        else if (rd_pend)                     sel_rd = 1'b1;
        if (sel_wr)
          state_nxt = (wr_cls.illegal || wr_cls.kind == K_CSR) ? ST_B_RESP : ST_WR_WAIT;
        else if (sel_rd)
          state_nxt = (rd_cls.illegal || rd_cls.kind == K_CSR) ? ST_R_RESP : ST_RD_WAIT;
      end
      ST_WR_WAIT: if (ll_valid || tmo_hit) state_nxt = ST_B_RESP;
      ST_RD_WAIT: if (ll_valid || tmo_hit) state_nxt = ST_R_RESP;
      ST_B_RESP:  if (BREADY) state_nxt = ST_IDLE;
      ST_R_RESP:  if (RREADY) state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // one-entry AW / W / AR holding registers, freed on response acceptance
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdy_en  <= 1'b0;
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      ar_full <= 1'b0;
      aw_addr <= '0;
      ar_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
    end else begin
      rdy_en <= 1'b1;
      if (AWVALID && AWREADY) begin
        aw_full <= 1'b1;
        aw_addr <= AWADDR;
      end
      if (WVALID && WREADY) begin
        w_full <= 1'b1;
        w_data <= WDATA;
        w_strb <= WSTRB;
      end
      if (ARVALID && ARREADY) begin
        ar_full <= 1'b1;
        ar_addr <= ARADDR;
      end
      if (state == ST_B_RESP && BREADY) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
      end
      if (state == ST_R_RESP && RREADY) ar_full <= 1'b0;
    end
  end

  // backend request launch, CSR side effects, completion and timeout
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      pri_rd       <= 1'b0;
      tmo_sticky   <= 1'b0;
      ll_spd       <= 1'b1;
      ll_dir       <= 1'b0;
      ll_erase     <= 1'b0;
      ll_erase_blk <= 1'b0;
      ll_address   <= '0;
      ll_word      <= '0;
      cnt          <= '0;
      BRESP        <= RESP_OKAY;
      RRESP        <= RESP_OKAY;
      RDATA        <= '0;
    end else begin
      if ((sel_wr || sel_rd) && wr_pend && rd_pend) pri_rd <= ~pri_rd;
      if (sel_wr) begin
        cnt <= '0;
        if (wr_cls.illegal) begin
          BRESP <= RESP_SLVERR;
        end else if (wr_cls.kind == K_CSR) begin
          BRESP  <= RESP_OKAY;
          ll_spd <= w_data[0];
          if (w_data[1]) tmo_sticky <= 1'b0;
        end else begin
          ll_address   <= aw_addr[FLASH_AW-1:0];
          ll_word      <= w_data;
          ll_dir       <= 1'b1;
          ll_erase     <= (wr_cls.kind != K_DATA);
          ll_erase_blk <= (wr_cls.kind == K_BLK);
        end
      end
      if (sel_rd) begin
        cnt <= '0;
        if (rd_cls.illegal) begin
          RRESP <= RESP_SLVERR;
          RDATA <= '0;
        end else if (rd_cls.kind == K_CSR) begin
          RRESP <= RESP_OKAY;
          RDATA <= {29'b0, ll_spd, tmo_sticky, ll_busy};
        end else begin
          ll_address   <= ar_addr[FLASH_AW-1:0];
          ll_dir       <= 1'b0;
          ll_erase     <= 1'b0;
          ll_erase_blk <= 1'b0;
        end
      end
      if (state == ST_WR_WAIT || state == ST_RD_WAIT) begin
        if (ll_valid) begin
          BRESP <= RESP_OKAY;
          RRESP <= RESP_OKAY;
          if (state == ST_RD_WAIT) RDATA <= ll_word_in;
        end else if (tmo_hit) begin
          BRESP      <= RESP_SLVERR;
          RRESP      <= RESP_SLVERR;
          tmo_sticky <= 1'b1;
          if (state == ST_RD_WAIT) RDATA <= TIMEOUT_FILL;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_axil_flash_bridge.sv
// Scoreboard bench for axil_flash_bridge: directed traffic, queued expectations.
module tb_axil_flash_bridge;

  logic        ACLK, ARESET;
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, ll_word, ll_word_in;
  logic [2:0]  AWPROT, ARPROT;
  logic [3:0]  WSTRB;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0]  BRESP, RRESP;
  logic        ll_start, ll_dir, ll_erase, ll_erase_blk, ll_spd, ll_valid, ll_busy;
  logic [23:0] ll_address;

  typedef struct {
    logic [23:0] addr;
    logic        dir, erase, blk;
    logic [31:0] word;
    logic        chk_word;
  } ll_exp_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    logic        chk_data;
  } r_exp_t;

  ll_exp_t    exp_ll[$];
  logic [1:0] exp_b[$];
  r_exp_t     exp_r[$];

  int checks = 0, failures = 0, cyc = 0;
  int be_delay = 1, valid_cyc = 0;
  logic be_never = 1'b0;
  logic [31:0] be_data = '0;

  axil_flash_bridge #(.TIMEOUT_CYC(16)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BVALID(BVALID), .BRESP(BRESP), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RVALID(RVALID), .RDATA(RDATA), .RRESP(RRESP), .RREADY(RREADY),
    .ll_start(ll_start), .ll_dir(ll_dir), .ll_erase(ll_erase),
    .ll_erase_blk(ll_erase_blk), .ll_spd(ll_spd), .ll_address(ll_address),
    .ll_word(ll_word), .ll_word_in(ll_word_in), .ll_valid(ll_valid), .ll_busy(ll_busy)
  );

  initial begin
    ACLK = 1'b0;
    forever #5 ACLK = ~ACLK;
  end

  always @(posedge ACLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tmo(input string nm);
    checks++;
    failures++;
    $display("FAIL %s: event not seen within its cycle budget", nm);
  endtask

  task automatic tick();
    @(negedge ACLK);
  endtask

  task automatic push_ll(input logic [23:0] a, input logic d, input logic e,
                         input logic b, input logic [31:0] w, input logic cw);
    ll_exp_t x;
    x.addr = a; x.dir = d; x.erase = e; x.blk = b; x.word = w; x.chk_word = cw;
    exp_ll.push_back(x);
  endtask

  task automatic push_r(input logic [1:0] r, input logic [31:0] d, input logic cd);
    r_exp_t x;
    x.resp = r; x.data = d; x.chk_data = cd;
    exp_r.push_back(x);
  endtask

  task automatic send_aw(input logic [31:0] a, output int c);
    AWADDR = a; AWVALID = 1'b1; c = -1;
    for (int i = 0; i < 50; i++) begin
      if (AWREADY) begin c = cyc; break; end
      tick();
    end
    if (c < 0) tmo("aw_handshake");
    tick();
    AWVALID = 1'b0;
  endtask

  task automatic send_w(input logic [31:0] d, input logic [3:0] s, output int c);
    WDATA = d; WSTRB = s; WVALID = 1'b1; c = -1;
    for (int i = 0; i < 50; i++) begin
      if (WREADY) begin c = cyc; break; end
      tick();
    end
    if (c < 0) tmo("w_handshake");
    tick();
    WVALID = 1'b0;
  endtask

  task automatic send_ar(input logic [31:0] a);
    int c;
    ARADDR = a; ARVALID = 1'b1; c = -1;
    for (int i = 0; i < 50; i++) begin
      if (ARREADY) begin c = cyc; break; end
      tick();
    end
    if (c < 0) tmo("ar_handshake");
    tick();
    ARVALID = 1'b0;
  endtask

  // AW and W offered together; each drops independently once taken
  task automatic send_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic aw_d, w_d;
    AWADDR = a; WDATA = d; WSTRB = s; AWVALID = 1'b1; WVALID = 1'b1;
    aw_d = 1'b0; w_d = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (AWVALID && AWREADY) aw_d = 1'b1;
      if (WVALID && WREADY)   w_d  = 1'b1;
      tick();
      if (aw_d) AWVALID = 1'b0;
      if (w_d)  WVALID  = 1'b0;
      if (aw_d && w_d) break;
    end
    if (!(aw_d && w_d)) tmo("wr_handshake");
    AWVALID = 1'b0; WVALID = 1'b0;
  endtask

  // which: 0 = ll_start, 1 = BVALID, 2 = RVALID
  task automatic wait_for(input string nm, input int which, input int budget, output int c);
    logic s;
    c = -1;
    for (int i = 0; i < budget; i++) begin
      s = (which == 0) ? ll_start : (which == 1) ? BVALID : RVALID;
      if (s) begin c = cyc; break; end
      tick();
    end
    if (c < 0) tmo(nm);
  endtask

  task automatic wait_idle(input string nm);
    logic done;
    done = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (exp_b.size() == 0 && exp_r.size() == 0 && exp_ll.size() == 0 &&
          !BVALID && !RVALID && !ll_start) begin
        done = 1'b1;
        break;
      end
      tick();
    end
    if (!done) tmo(nm);
    tick();
  endtask

  // backend model: answers ll_start after be_delay cycles unless be_never
  initial begin : backend
    int w;
    w = 0;
    ll_valid = 1'b0;
    ll_word_in = '0;
    forever begin
      @(negedge ACLK);
      ll_valid = 1'b0;
      if (ll_start && !be_never) begin
        if (w == be_delay) begin
          ll_valid = 1'b1;
          ll_word_in = be_data;
          valid_cyc = cyc;
          w = 0;
        end else w++;
      end else w = 0;
    end
  end

  // monitor: compares responses and backend requests against the queues
  initial begin : monitor
    logic st_q;
    logic [1:0] eb;
    r_exp_t er;
    ll_exp_t el;
    st_q = 1'b0;
    forever begin
      @(negedge ACLK);
      #3;
      if (BVALID && BREADY) begin
        if (exp_b.size() == 0) tmo("b_unexpected");
        else begin
          eb = exp_b.pop_front();
          chk("bresp", BRESP, eb);
        end
      end
      if (RVALID && RREADY) begin
        if (exp_r.size() == 0) tmo("r_unexpected");
        else begin
          er = exp_r.pop_front();
          chk("rresp", RRESP, er.resp);
          if (er.chk_data) chk("rdata", RDATA, er.data);
        end
      end
      if (ll_start && !st_q) begin
        if (exp_ll.size() == 0) tmo("ll_start_unexpected");
        else begin
          el = exp_ll.pop_front();
          chk("ll_req", {ll_address, ll_dir, ll_erase, ll_erase_blk},
              {el.addr, el.dir, el.erase, el.blk});
          if (el.chk_word) chk("ll_word", ll_word, el.word);
        end
      end
      st_q = ll_start;
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t_aw, t_w, s, b, r;
    ARESET = 1'b1; AWADDR = '0; AWPROT = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WVALID = 1'b0; BREADY = 1'b1;
    ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b1; ll_busy = 1'b0;
    repeat (3) tick();

    // reset state
    chk("rst_ready", {AWREADY, WREADY, ARREADY}, 3'b000);
    chk("rst_valid", {BVALID, RVALID, ll_start}, 3'b000);
    chk("rst_resp", {BRESP, RRESP}, 4'h0);
    chk("rst_rdata", RDATA, 32'h0);
    chk("rst_spd", ll_spd, 1'b1);
    ARESET = 1'b0;
    chk("ready_at_release", AWREADY, 1'b0);
    tick();
    chk("ready_after_release", {AWREADY, WREADY, ARREADY}, 3'b111);

    // program: AW at T, W at T+3, slow backend, stalled B
    BREADY = 1'b0; be_delay = 4;
    push_ll(24'h000010, 1'b1, 1'b0, 1'b0, 32'h1234_5678, 1'b1);
    exp_b.push_back(2'b00);
    send_aw(32'h0100_0010, t_aw);
    tick(); tick();
    send_w(32'h1234_5678, 4'hF, t_w);
    wait_for("prog_start", 0, 20, s);
    if (s >= 0) chk("prog_start_lat", s - t_aw, 5);
    wait_for("prog_bvalid", 1, 30, b);
    if (b >= 0) chk("prog_bvalid_lat", b - valid_cyc, 1);
    repeat (3) begin
      chk("b_hold", {BVALID, BRESP}, 3'b100);
      tick();
    end
    BREADY = 1'b1;
    tick();
    chk("b_drop", BVALID, 1'b0);
    wait_idle("prog_idle");

    // data read
    be_delay = 2; be_data = 32'hCAFE_F00D;
    push_ll(24'h000020, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_r(2'b00, 32'hCAFE_F00D, 1'b1);
    send_ar(32'h0100_0020);
    wait_idle("read_idle");

    // block erase (strobes irrelevant), then erase via AR is rejected
    push_ll(24'h001000, 1'b1, 1'b1, 1'b1, 32'h0, 1'b0);
    exp_b.push_back(2'b00);
    send_wr(32'h0400_1000, 32'hFFFF_FFFF, 4'h0);
    wait_idle("blk_idle");
    push_r(2'b10, 32'h0, 1'b0);
    send_ar(32'h0200_0000);
    wait_idle("ar_erase_idle");

    // collision 1: write wins, read follows
    ll_busy = 1'b1; be_delay = 1; be_data = 32'h1111_2222;
    push_ll(24'h000040, 1'b1, 1'b0, 1'b0, 32'h0000_AAAA, 1'b1);
    push_ll(24'h000044, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    exp_b.push_back(2'b00);
    push_r(2'b00, 32'h1111_2222, 1'b1);
    send_wr(32'h0100_0040, 32'h0000_AAAA, 4'hF);
    send_ar(32'h0100_0044);
    tick();
    ll_busy = 1'b0;
    wait_idle("coll1_idle");

    // collision 2: read wins this time
    ll_busy = 1'b1; be_data = 32'h3333_4444;
    push_ll(24'h000048, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_ll(24'h00004C, 1'b1, 1'b0, 1'b0, 32'h0000_BBBB, 1'b1);
    exp_b.push_back(2'b00);
    push_r(2'b00, 32'h3333_4444, 1'b1);
    send_wr(32'h0100_004C, 32'h0000_BBBB, 4'hF);
    send_ar(32'h0100_0048);
    tick();
    ll_busy = 1'b0;
    wait_idle("coll2_idle");

    // timeout on a read: SLVERR at WAIT cycle 17, fill data
    be_never = 1'b1;
    push_ll(24'h000050, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    push_r(2'b10, 32'hDEAD_BEEF, 1'b1);
    send_ar(32'h0100_0050);
    wait_for("tmo_start", 0, 20, s);
    wait_for("tmo_rvalid", 2, 40, r);
    if (s >= 0 && r >= 0) chk("tmo_lat", r - s, 16);
    chk("tmo_start_low", ll_start, 1'b0);
    wait_idle("tmo_idle");
    be_never = 1'b0;

    // CSR: sticky visible, then cleared by writing 0x2 (also sets spd 0)
    push_r(2'b00, 32'h0000_0006, 1'b1);
    send_ar(32'h0000_0000);
    wait_idle("csr_rd1_idle");
    exp_b.push_back(2'b00);
    send_wr(32'h0000_0000, 32'h0000_0002, 4'hF);
    wait_idle("csr_wr_idle");
    chk("csr_spd", ll_spd, 1'b0);
    push_r(2'b00, 32'h0000_0000, 1'b1);
    send_ar(32'h0000_0000);
    wait_idle("csr_rd2_idle");

    // reset while waiting on the backend
    be_never = 1'b1;
    push_ll(24'h000060, 1'b1, 1'b0, 1'b0, 32'hA5A5_0001, 1'b1);
    exp_b.push_back(2'b00);
    send_wr(32'h0100_0060, 32'hA5A5_0001, 4'hF);
    wait_for("rst_op_start", 0, 20, s);
    tick();
    ARESET = 1'b1;
    tick();
    chk("rst_mid_start", ll_start, 1'b0);
    chk("rst_mid_bvalid", BVALID, 1'b0);
    exp_b.delete();
    tick();
    ARESET = 1'b0;
    be_never = 1'b0;
    tick();
    chk("rst_mid_ready", {AWREADY, WREADY, ARREADY}, 3'b111);
    chk("rst_mid_spd", ll_spd, 1'b1);
    push_r(2'b00, 32'h0000_0004, 1'b1);
    send_ar(32'h0000_0000);
    wait_idle("rst_csr_idle");

    // partial-strobe program is rejected
    exp_b.push_back(2'b10);
    send_wr(32'h0100_0070, 32'h5555_5555, 4'h3);
    wait_idle("strb_idle");

    // sector erase
    push_ll(24'h000100, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
    exp_b.push_back(2'b00);
    send_wr(32'h0200_0100, 32'h0, 4'hF);
    wait_idle("sect_idle");

    // unknown op write and unaligned read
    exp_b.push_back(2'b10);
    send_wr(32'h0300_0000, 32'h0, 4'hF);
    wait_idle("badop_idle");
    push_r(2'b10, 32'h0, 1'b0);
    send_ar(32'h0100_0022);
    wait_idle("unaligned_idle");

    chk("queues_empty", exp_b.size() + exp_r.size() + exp_ll.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
